// File: rtl/rst_sync_seq.sv
// Reset synchroniser and release sequencer: asynchronous assert, synchronous staged release
// of NUM_OUTS active-low resets in index order, re-runnable by a software request.
module rst_sync_seq #(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_OUTS    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SW_RST_REQ,
  output logic [NUM_OUTS-1:0] SYNC_RST,
  output logic                RST_DONE
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [NUM_STAGES-1:0] sync_q;
  logic                  src_ok;
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [NUM_OUTS-1:0]   rst_q, rst_d, rel_next;
  logic                  done_q, done_d, do_rel;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '0;
    else      sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
  end

  assign src_ok = sync_q[NUM_STAGES-1];

  // The edge that first sees src_ok already counts toward the hold period,
  // so HOLD is entered with count 1 (or bit 0 releases at once for a 1-cycle hold).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rst_d    = rst_q;
    done_d   = done_q;
    do_rel   = 1'b0;
    cnt_inc  = cnt_q + CW'(1);
    rel_next = rst_q << 1;
    rel_next[0] = 1'b1;
    if (SW_RST_REQ) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (src_ok) begin
            if (HOLD_CYCLES == 1) begin
              do_rel = 1'b1;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (cnt_inc == CW'(HOLD_CYCLES)) do_rel = 1'b1;
          else                             cnt_d  = cnt_inc;
        end
        ST_RELEASE: begin
          if (cnt_inc == CW'(GAP_CYCLES)) do_rel = 1'b1;
          else                            cnt_d  = cnt_inc;
        end
        default: ;
      endcase
      // Releasing by shifting in a 1 keeps the released bits a low-index prefix.
      if (do_rel) begin
        rst_d = rel_next;
        cnt_d = '0;
        if (&rel_next) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RELEASE;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  assign SYNC_RST = rst_q;
  assign RST_DONE = done_q;

endmodule
